// File: rtl/ps2_cmd_pkg.sv
// Shared types and constants for the ASCII-hex to PS/2 command parser.
package ps2_cmd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NIB_W  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIG1   = 3'd1,
        DIG2   = 3'd2,
        RESYNC = 3'd3,
        SEND   = 3'd4,
        WAIT   = 3'd5
    } state_t;

    localparam logic [BYTE_W-1:0] SP = 8'h20;
    localparam logic [BYTE_W-1:0] CR = 8'h0D;
    localparam logic [BYTE_W-1:0] LF = 8'h0A;

endpackage

// File: rtl/ascii_hex_decoder.sv
// Classifies one ASCII character as hex digit / token terminator and yields its nibble.
module ascii_hex_decoder
    import ps2_cmd_pkg::*;
(
    input  logic [BYTE_W-1:0] ch,
    output logic [NIB_W-1:0]  nibble,
    output logic              is_hex,
    output logic              is_term
);

    // Letters A-F / a-f share the low nibble 1..6, offset by 9 to reach 10..15.
    always_comb begin
        nibble = '0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            is_hex = 1'b1;
            nibble = ch[3:0];
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            is_hex = 1'b1;
            nibble = ch[3:0] + 4'd9;
        end
    end

    assign is_term = (ch == SP) || (ch == CR) || (ch == LF);

endmodule

// File: rtl/ps2_cmd_parser.sv
// Turns ASCII hex tokens from the UART RX FIFO into PS/2 host-to-device command writes,
// one at a time, waiting for tx_done (or a timeout) before reading further input.
module ps2_cmd_parser
    import ps2_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [BYTE_W-1:0] rd_data,
    output logic              rd_uart,
    input  logic              tx_done,
    output logic              wr_ps2,
    output logic [BYTE_W-1:0] ps2_din,
    output logic              busy,
    output logic              cmd_err,
    output logic              tx_timeout
);

    state_t             state, state_d;
    logic [NIB_W-1:0]   hi, hi_d, lo, lo_d;
    logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
    logic [BYTE_W-1:0]  ps2_din_d;
    logic               wr_ps2_d, busy_d, cmd_err_d, tx_timeout_d;
    logic [NIB_W-1:0]   nibble;
    logic               is_hex, is_term;
    logic               read_state;

    ascii_hex_decoder u_dec (
        .ch      (rd_data),
        .nibble  (nibble),
        .is_hex  (is_hex),
        .is_term (is_term)
    );

    // The pop strobe must coincide with consumption of the FWFT head, so it is combinational.
    assign read_state = (state == IDLE) || (state == DIG1) || (state == DIG2) || (state == RESYNC);
    assign rd_uart    = !reset && read_state && !rx_empty;
    assign cnt_inc    = cnt + CNT_W'(1);

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d      = state;
        hi_d         = hi;
        lo_d         = lo;
        cnt_d        = cnt;
        ps2_din_d    = ps2_din;
        wr_ps2_d     = 1'b0;
        cmd_err_d    = 1'b0;
        tx_timeout_d = 1'b0;

        case (state)
            IDLE: begin
                if (rd_uart) begin
                    if (is_hex) begin
                        hi_d    = nibble;
                        state_d = DIG1;
                    end else if (!is_term) begin
                        cmd_err_d = 1'b1;
                        state_d   = RESYNC;
                    end
                end
            end
            DIG1: begin
                if (rd_uart) begin
                    if (is_hex) begin
                        lo_d    = nibble;
                        state_d = DIG2;
                    end else if (is_term) begin
                        ps2_din_d = {4'h0, hi};
                        wr_ps2_d  = 1'b1;
                        state_d   = SEND;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = RESYNC;
                    end
                end
            end
            DIG2: begin
                if (rd_uart) begin
                    if (is_term) begin
                        ps2_din_d = {hi, lo};
                        wr_ps2_d  = 1'b1;
                        state_d   = SEND;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = RESYNC;
                    end
                end
            end
            RESYNC: begin
                if (rd_uart && is_term) begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // tx_done takes priority over a timeout landing on the same cycle.
                if (tx_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        tx_timeout_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SEND) || (state_d == WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hi         <= '0;
            lo         <= '0;
            cnt        <= '0;
            ps2_din    <= '0;
            wr_ps2     <= 1'b0;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            state      <= state_d;
            hi         <= hi_d;
            lo         <= lo_d;
            cnt        <= cnt_d;
            ps2_din    <= ps2_din_d;
            wr_ps2     <= wr_ps2_d;
            busy       <= busy_d;
            cmd_err    <= cmd_err_d;
            tx_timeout <= tx_timeout_d;
        end
    end

endmodule

// File: tb/tb_ps2_cmd_parser.sv
// Directed bench for ps2_cmd_parser: FWFT FIFO model, tx_done responder, vector table plus corner sequences.
module tb_ps2_cmd_parser;

    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] rd_data = 8'h00;
    logic       tx_done = 1'b0;
    logic       rd_uart, wr_ps2, busy, cmd_err, tx_timeout;
    logic [7:0] ps2_din;

    ps2_cmd_parser #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .rd_data    (rd_data),
        .rd_uart    (rd_uart),
        .tx_done    (tx_done),
        .wr_ps2     (wr_ps2),
        .ps2_din    (ps2_din),
        .busy       (busy),
        .cmd_err    (cmd_err),
        .tx_timeout (tx_timeout)
    );

    typedef struct {
        logic [63:0] text;
        int          len;
        int          n_wr;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          n_err;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] q[$];
    logic [7:0] wr_bytes[$];
    int         wr_cycs[$];
    int         pop_cycs[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         resp_delay = 50;
    int         countdown = 0;
    int         err_cnt = 0, to_cnt = 0, to_cyc = 0, busy_pop = 0, txdone_cyc = 0;
    logic       busy_at_wr = 1'b0, busy_at_to = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void refresh();
        rx_empty = (q.size() == 0);
        rd_data  = (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    // FIFO model and output monitor: rd_uart sampled mid-cycle, head popped just after the edge.
    initial begin
        logic p;
        forever begin
            @(negedge clk);
            p = rd_uart;
            if (p) pop_cycs.push_back(cyc);
            if (p && busy) busy_pop++;
            if (cmd_err) err_cnt++;
            if (tx_timeout) begin
                to_cnt++;
                to_cyc     = cyc;
                busy_at_to = busy;
            end
            @(posedge clk);
            #1;
            if (p && q.size() != 0) begin
                void'(q.pop_front());
                refresh();
            end
        end
    end

    // PS/2 transmitter stand-in: logs writes, answers tx_done after resp_delay cycles (0 = never).
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (wr_ps2) begin
                wr_bytes.push_back(ps2_din);
                wr_cycs.push_back(cyc);
                busy_at_wr = busy;
                countdown  = resp_delay;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    tx_done    = 1'b1;
                    txdone_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_text(input logic [63:0] t, input int len);
        @(posedge clk);
        #2;
        for (int i = 0; i < len; i++) q.push_back(t[8*(len-1-i) +: 8]);
        refresh();
    endtask

    task automatic clear_logs();
        wr_bytes.delete();
        wr_cycs.delete();
        pop_cycs.delete();
        err_cnt  = 0;
        to_cnt   = 0;
        busy_pop = 0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(q.size() == 0 && !busy) && n < max);
        check({name, "_idle"}, int'(n < max), 1);
        repeat (3) tick();
    endtask

    task automatic wait_writes(input string name, input int cnt, input int max);
        int n = 0;
        while (wr_bytes.size() < cnt && n < max) begin
            tick();
            n++;
        end
        check({name, "_wr_seen"}, int'(wr_bytes.size() >= cnt), 1);
    endtask

    initial begin
        vecs[0] = '{text: "F4 ",     len: 3, n_wr: 1, b0: 8'hF4, b1: 8'h00, n_err: 0};
        vecs[1] = '{text: "ff\r5\n", len: 5, n_wr: 2, b0: 8'hFF, b1: 8'h05, n_err: 0};
        vecs[2] = '{text: "G4 ED ",  len: 6, n_wr: 1, b0: 8'hED, b1: 8'h00, n_err: 1};
        vecs[3] = '{text: "123 AA ", len: 7, n_wr: 1, b0: 8'hAA, b1: 8'h00, n_err: 1};
        vecs[4] = '{text: " \nc\r",  len: 4, n_wr: 1, b0: 8'h0C, b1: 8'h00, n_err: 0};
        vecs[5] = '{text: "7$ 9 ",   len: 5, n_wr: 1, b0: 8'h09, b1: 8'h00, n_err: 1};

        // Reset values
        repeat (3) tick();
        check("rst_rd_uart", int'(rd_uart), 0);
        check("rst_wr_ps2", int'(wr_ps2), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cmd_err", int'(cmd_err), 0);
        check("rst_tx_timeout", int'(tx_timeout), 0);
        check("rst_ps2_din", int'(ps2_din), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) tick();

        // Table-driven tokens
        resp_delay = 50;
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            push_text(vecs[v].text, vecs[v].len);
            wait_idle($sformatf("vec%0d", v), 1000);
            check($sformatf("vec%0d_nwr", v), wr_bytes.size(), vecs[v].n_wr);
            if (wr_bytes.size() > 0) check($sformatf("vec%0d_b0", v), int'(wr_bytes[0]), int'(vecs[v].b0));
            if (vecs[v].n_wr > 1 && wr_bytes.size() > 1)
                check($sformatf("vec%0d_b1", v), int'(wr_bytes[1]), int'(vecs[v].b1));
            check($sformatf("vec%0d_err", v), err_cnt, vecs[v].n_err);
            check($sformatf("vec%0d_pops", v), pop_cycs.size(), vecs[v].len);
            check($sformatf("vec%0d_busy_pop", v), busy_pop, 0);
            check($sformatf("vec%0d_tmo", v), to_cnt, 0);
        end

        // "F4 " then "5 ": write latency, busy, and resume after tx_done
        clear_logs();
        push_text("F4 5 ", 5);
        wait_writes("seq1", 1, 200);
        check("seq1_pops_before_wr", pop_cycs.size(), 3);
        if (wr_bytes.size() > 0 && pop_cycs.size() >= 3) begin
            check("seq1_byte", int'(wr_bytes[0]), 8'hF4);
            check("seq1_wr_latency", wr_cycs[0] - pop_cycs[2], 1);
            check("seq1_busy_at_wr", int'(busy_at_wr), 1);
        end
        for (int n = 0; n < 200 && pop_cycs.size() < 4; n++) tick();
        check("seq1_next_pop_seen", int'(pop_cycs.size() >= 4), 1);
        if (pop_cycs.size() >= 4 && wr_cycs.size() > 0) begin
            check("seq1_txdone_delay", txdone_cyc - wr_cycs[0], 50);
            check("seq1_pop_after_done", pop_cycs[3] - txdone_cyc, 1);
        end
        wait_idle("seq1", 1000);
        check("seq1_nwr", wr_bytes.size(), 2);
        if (wr_bytes.size() > 1) check("seq1_byte2", int'(wr_bytes[1]), 8'h05);
        check("seq1_din_held", int'(ps2_din), 8'h05);

        // Timeout with tx_done never returned
        clear_logs();
        resp_delay = 0;
        push_text("FF ", 3);
        for (int n = 0; n < 400 && to_cnt == 0; n++) tick();
        check("tmo_seen", to_cnt, 1);
        if (wr_cycs.size() > 0) begin
            check("tmo_distance", to_cyc - wr_cycs[0], 100);
            check("tmo_byte", int'(wr_bytes[0]), 8'hFF);
        end
        check("tmo_busy_dropped", int'(busy_at_to), 0);
        check("tmo_no_pop_in_wait", busy_pop, 0);
        repeat (3) tick();
        check("tmo_single_pulse", to_cnt, 1);
        check("tmo_din_held", int'(ps2_din), 8'hFF);

        // Reset while waiting, with "F3 " queued behind
        clear_logs();
        push_text("11 ", 3);
        wait_writes("rstw", 1, 200);
        repeat (5) tick();
        push_text("F3 ", 3);
        repeat (5) tick();
        check("rstw_no_pop_in_wait", pop_cycs.size(), 3);
        check("rstw_busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        check("rstw_rd_uart", int'(rd_uart), 0);
        check("rstw_busy", int'(busy), 0);
        check("rstw_wr_ps2", int'(wr_ps2), 0);
        check("rstw_ps2_din", int'(ps2_din), 0);
        check("rstw_err_tmo", int'(cmd_err | tx_timeout), 0);
        repeat (2) tick();
        resp_delay = 20;
        @(posedge clk);
        #2;
        reset = 1'b0;
        wait_idle("rstw", 1000);
        check("rstw_nwr", wr_bytes.size(), 2);
        if (wr_bytes.size() > 1) check("rstw_byte", int'(wr_bytes[1]), 8'hF3);
        check("rstw_err", err_cnt, 0);
        check("rstw_tmo", to_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_parser.md
Name: ps2_cmd_parser

Overview:
- Host-to-device counterpart of the PS/2 monitor path: reads ASCII hex tokens from the UART receive FIFO and turns each into one command byte for the PS/2 transmitter.
- Example: UART text "F4 " makes the block issue PS/2 write 0xF4.
- Sits between uart (rd_uart/rd_data/rx_empty) and ps2_rx_tx (wr_ps2/din/tx_done). It issues one command at a time and waits for completion before reading more input.

Parameters:
- TIMEOUT_CYCLES, 1000000, clk cycles to wait for tx_done after wr_ps2 before aborting (20 ms at 50 MHz).
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_empty  input  1  UART receive FIFO empty.
- rd_data  input  8  UART FIFO head byte (first-word fall-through, valid while rx_empty=0).
- rd_uart  output  1  one-cycle pop strobe to the UART FIFO.
- tx_done  input  1  one-cycle pulse from ps2_rx_tx when the host-to-device byte completes.
- wr_ps2  output  1  one-cycle start strobe to ps2_rx_tx.
- ps2_din  output  8  command byte to ps2_rx_tx; held stable from wr_ps2 until the block leaves WAIT.
- busy  output  1  high in SEND and WAIT.
- cmd_err  output  1  one-cycle pulse on a malformed token.
- tx_timeout  output  1  one-cycle pulse when tx_done does not arrive within TIMEOUT_CYCLES.

Behaviour:
- Reset (async): state=IDLE; rd_uart, wr_ps2, busy, cmd_err and tx_timeout = 0; ps2_din=0x00; digit register and count cleared.
- Character classes:
  - hex: '0'-'9', 'A'-'F', 'a'-'f';
  - terminator: 0x20 (SP), 0x0D (CR), 0x0A (LF);
  - anything else is invalid.
- Reading: in IDLE, DIG1, DIG2 and RESYNC, when rx_empty=0 the block asserts rd_uart for exactly that cycle and consumes rd_data in the same cycle. There are no back-to-back pops without rx_empty=0, and no pops in SEND or WAIT; the FIFO provides backpressure.
- State transitions on a consumed character:
  - IDLE: hex -> store nibble as hi, go DIG1. Terminator -> ignored, stay IDLE. Invalid -> cmd_err, go RESYNC.
  - DIG1: hex -> store lo, go DIG2. Terminator -> byte = {4'h0, hi}, go SEND. Invalid -> cmd_err, go RESYNC.
  - DIG2: terminator -> byte = {hi, lo}, go SEND. Hex (third digit) or invalid -> cmd_err, go RESYNC.
  - RESYNC: discard characters until a terminator is consumed, then go IDLE. No further cmd_err until then.
- SEND (one cycle):
  - wr_ps2=1 and ps2_din=byte; clear the timeout counter; go WAIT.
  - So the latency from popping the terminator to wr_ps2 is 1 cycle.
- WAIT:
  - tx_done=1 -> go IDLE.
  - Otherwise increment the counter; when it reaches TIMEOUT_CYCLES-1, pulse tx_timeout and go IDLE.
  - If tx_done arrives in the same cycle as the final count, tx_done wins and there is no tx_timeout.
  - tx_done is ignored in every state except WAIT, including the SEND cycle.
- ps2_din keeps its value after WAIT until the next SEND.
- cmd_err and tx_timeout are registered pulses, asserted the cycle after the causing event.
- Reset asserted mid-WAIT or mid-token aborts immediately. The partial token is lost and no wr_ps2 is issued.

Decomposition:
- Shared package ps2_cmd_pkg holds:
  - state encoding: IDLE, DIG1, DIG2, RESYNC, SEND, WAIT (3 bits);
  - ASCII constants: SP=8'h20, CR=8'h0D, LF=8'h0A.
- One natural combinational sub-module, ascii_hex_decoder: input 8-bit char; outputs nibble[3:0], is_hex and is_term.

Test Plan:
- Feed "F4 " into the FIFO model -> three rd_uart pulses; wr_ps2 one cycle after the SP pop with ps2_din=0xF4 and busy=1. Bench returns tx_done after 50 cycles -> busy=0, IDLE, and the next char is popped.
- Feed "ff\r5\n" -> wr_ps2 with 0xFF, then after tx_done wr_ps2 with 0x05; no cmd_err.
- Feed "G4 ED " -> cmd_err once and no wr_ps2 for the first token; the block resyncs on SP, then wr_ps2 with 0xED.
- Feed "123 " -> cmd_err on '3' and no write; IDLE after SP; a following "AA " yields 0xAA.
- TIMEOUT_CYCLES=100, feed "FF ", never send tx_done -> tx_timeout pulses exactly 100 cycles after wr_ps2; busy drops and no rd_uart occurs during WAIT.
- Assert reset in WAIT while "F3 " is queued -> all outputs 0 within the reset cycle; after release the queued chars parse normally to 0xF3.
